// File: rtl/sig_source_pkg.sv
// Shared constants and table helpers for the sig_source antenna selector.
// Tables are packed vectors with entry k at [k*FIELD +: FIELD].
package sig_source_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_SBITS = 4;
  localparam int DEF_XBITS = 3;
  localparam int DEF_MUX_N = 5;
  localparam int DEF_TRATE = 6;
  localparam int DEF_TBITS = 3;

  localparam logic [DEF_SBITS*DEF_MUX_N-1:0] DEF_ATAPS = {4'd1, 4'd5, 4'd7, 4'd8, 4'd11};
  localparam logic [DEF_SBITS*DEF_MUX_N-1:0] DEF_BTAPS = {4'd0, 4'd2, 4'd3, 4'd9, 4'd10};
  localparam logic [DEF_XBITS*DEF_TRATE-1:0] DEF_ASELS = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  localparam logic [DEF_XBITS*DEF_TRATE-1:0] DEF_BSELS = {3'd1, 3'd1, 3'd2, 3'd4, 3'd0, 3'd3};

  // Tables are passed zero-extended to 64 bits so one helper serves every table.
  function automatic logic [31:0] get_field(input logic [63:0] tbl, input int k, input int fbits);
    logic [31:0] mask;
    mask = (32'd1 << fbits) - 32'd1;
    return 32'(tbl >> (k * fbits)) & mask;
  endfunction

endpackage

// File: rtl/sig_source_if.sv
// Beat-level bus between a sample producer/consumer and the sig_source selector.
interface sig_source_if
  import sig_source_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TBITS = DEF_TBITS
);
  logic             valid_i;
  logic             first_i;
  logic             last_i;
  logic [TBITS-1:0] taddr_i;
  logic [WIDTH-1:0] idata_i;
  logic [WIDTH-1:0] qdata_i;
  logic             valid_o;
  logic             first_o;
  logic             last_o;
  logic             ai_o;
  logic             aq_o;
  logic             bi_o;
  logic             bq_o;

  modport master (
    output valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
    input  valid_o, first_o, last_o, ai_o, aq_o, bi_o, bq_o
  );

  modport slave (
    input  valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
    output valid_o, first_o, last_o, ai_o, aq_o, bi_o, bq_o
  );
endinterface

// File: rtl/sig_source_tap_mux.sv
// Slot -> mux select -> antenna lookup for one correlator port; purely combinational.
// Lookup arrays are padded to full index ranges so every index is in bounds.
module sig_tap_mux
  import sig_source_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SBITS = DEF_SBITS,
  parameter int XBITS = DEF_XBITS,
  parameter int MUX_N = DEF_MUX_N,
  parameter int TRATE = DEF_TRATE,
  parameter int TBITS = DEF_TBITS,
  parameter logic [XBITS*TRATE-1:0] SELS = DEF_ASELS,
  parameter logic [SBITS*MUX_N-1:0] TAPS = DEF_ATAPS
) (
  input  logic [TBITS-1:0] taddr_i,
  input  logic [WIDTH-1:0] idata_i,
  input  logic [WIDTH-1:0] qdata_i,
  output logic             i_o,
  output logic             q_o
);
  localparam int TSLOTS = 2 ** TBITS;
  localparam int XSLOTS = 2 ** XBITS;
  localparam int ANT    = 2 ** SBITS;

  logic [XBITS-1:0]  sel_lut_s [TSLOTS];
  logic [TSLOTS-1:0] sel_ok_s;
  logic [SBITS-1:0]  tap_lut_s [XSLOTS];
  logic [XSLOTS-1:0] tap_ok_s;
  logic [XBITS-1:0]  sel_s;
  logic [SBITS-1:0]  idx_s;
  logic [ANT-1:0]    iext_s;
  logic [ANT-1:0]    qext_s;

  for (genvar t = 0; t < TSLOTS; t++) begin : g_sel
    localparam int unsigned SEL = (t < TRATE) ? get_field(64'(SELS), t, XBITS) : 32'd0;
    assign sel_lut_s[t] = XBITS'(SEL);
    assign sel_ok_s[t]  = 1'((t < TRATE));
  end

  // Unused select codes and taps pointing past the array are flagged as misses.
  for (genvar k = 0; k < XSLOTS; k++) begin : g_tap
    localparam int unsigned TAP = (k < MUX_N) ? get_field(64'(TAPS), k, SBITS) : 32'd0;
    assign tap_lut_s[k] = SBITS'(TAP);
    assign tap_ok_s[k]  = 1'((k < MUX_N) && (TAP < WIDTH));
  end

  // Two-level table lookup; any out-of-range step forces both bits low.
  always_comb begin
    sel_s  = sel_lut_s[taddr_i];
    idx_s  = tap_lut_s[sel_s];
    iext_s = ANT'(idata_i);
    qext_s = ANT'(qdata_i);
    if (sel_ok_s[taddr_i] && tap_ok_s[sel_s]) begin
      i_o = iext_s[idx_s];
      q_o = qext_s[idx_s];
    end else begin
      i_o = 1'b0;
      q_o = 1'b0;
    end
  end
endmodule

// File: rtl/sig_source.sv
// Per-beat A/B antenna selector feeding one correlator, one registered cycle of latency.
// Data outputs hold between beats; framing flags pulse with each accepted beat.
module sig_source
  import sig_source_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SBITS = DEF_SBITS,
  parameter int XBITS = DEF_XBITS,
  parameter int MUX_N = DEF_MUX_N,
  parameter int TRATE = DEF_TRATE,
  parameter int TBITS = DEF_TBITS,
  parameter logic [SBITS*MUX_N-1:0] ATAPS = DEF_ATAPS,
  parameter logic [SBITS*MUX_N-1:0] BTAPS = DEF_BTAPS,
  parameter logic [XBITS*TRATE-1:0] ASELS = DEF_ASELS,
  parameter logic [XBITS*TRATE-1:0] BSELS = DEF_BSELS
) (
  input logic clock,
  input logic reset,
  sig_source_if.slave bus
);
  if (WIDTH > 2 ** SBITS) begin : g_err_width
    $error("sig_source: WIDTH does not fit in SBITS");
  end
  if (MUX_N > 2 ** XBITS) begin : g_err_mux
    $error("sig_source: MUX_N does not fit in XBITS");
  end
  if (TRATE > 2 ** TBITS) begin : g_err_trate
    $error("sig_source: TRATE does not fit in TBITS");
  end

  logic a_i_s, a_q_s, b_i_s, b_q_s;
  logic valid_d, first_d, last_d, ai_d, aq_d, bi_d, bq_d;
  logic valid_q, first_q, last_q, ai_q, aq_q, bi_q, bq_q;

  sig_tap_mux #(
    .WIDTH(WIDTH), .SBITS(SBITS), .XBITS(XBITS), .MUX_N(MUX_N),
    .TRATE(TRATE), .TBITS(TBITS), .SELS(ASELS), .TAPS(ATAPS)
  ) u_a_mux (
    .taddr_i(bus.taddr_i), .idata_i(bus.idata_i), .qdata_i(bus.qdata_i),
    .i_o(a_i_s), .q_o(a_q_s)
  );

  sig_tap_mux #(
    .WIDTH(WIDTH), .SBITS(SBITS), .XBITS(XBITS), .MUX_N(MUX_N),
    .TRATE(TRATE), .TBITS(TBITS), .SELS(BSELS), .TAPS(BTAPS)
  ) u_b_mux (
    .taddr_i(bus.taddr_i), .idata_i(bus.idata_i), .qdata_i(bus.qdata_i),
    .i_o(b_i_s), .q_o(b_q_s)
  );

  // Next-state: framing follows valid_i; data captured on beats, held otherwise.
  always_comb begin
    valid_d = bus.valid_i;
    first_d = bus.valid_i & bus.first_i;
    last_d  = bus.valid_i & bus.last_i;
    if (bus.valid_i) begin
      ai_d = a_i_s;
      aq_d = a_q_s;
      bi_d = b_i_s;
      bq_d = b_q_s;
    end else begin
      ai_d = ai_q;
      aq_d = aq_q;
      bi_d = bi_q;
      bq_d = bq_q;
    end
  end

  // Output registers; reset wins over a coincident beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ai_q    <= 1'b0;
      aq_q    <= 1'b0;
      bi_q    <= 1'b0;
      bq_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      ai_q    <= ai_d;
      aq_q    <= aq_d;
      bi_q    <= bi_d;
      bq_q    <= bq_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.first_o = first_q;
  assign bus.last_o  = last_q;
  assign bus.ai_o    = ai_q;
  assign bus.aq_o    = aq_q;
  assign bus.bi_o    = bi_q;
  assign bus.bq_o    = bq_q;
endmodule

// File: tb/tb_sig_source.sv
// Directed bench for sig_source: reset, table walk, frame stream, gaps, out-of-range, mid-stream reset.
module tb_sig_source;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  sig_source_if bus ();
  sig_source dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int atap [5] = '{11, 8, 7, 5, 1};
  int btap [5] = '{10, 9, 3, 2, 0};
  int asel [6] = '{0, 4, 3, 2, 1, 0};
  int bsel [6] = '{3, 0, 4, 2, 1, 1};
  int walk_a [6] = '{11, 1, 5, 7, 8, 11};
  int walk_b [6] = '{2, 10, 0, 3, 9, 9};

  logic ev, ef, el, eai, eaq, ebi, ebq;

  function automatic logic pick(input int t, input logic [11:0] d, input bit is_a);
    int s;
    int idx;
    if (t >= 6) return 1'b0;
    s = is_a ? asel[t] : bsel[t];
    if (s >= 5) return 1'b0;
    idx = is_a ? atap[s] : btap[s];
    if (idx >= 12) return 1'b0;
    return d[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic v, input logic f,
                      input logic l, input logic [2:0] t, input logic [11:0] i, input logic [11:0] q);
    reset       = rst;
    bus.valid_i = v;
    bus.first_i = f;
    bus.last_i  = l;
    bus.taddr_i = t;
    bus.idata_i = i;
    bus.qdata_i = q;
    @(posedge clock);
    #1;
    if (rst) begin
      {ev, ef, el, eai, eaq, ebi, ebq} = 7'd0;
    end else begin
      ev = v;
      ef = v & f;
      el = v & l;
      if (v) begin
        eai = pick(int'(t), i, 1'b1);
        eaq = pick(int'(t), q, 1'b1);
        ebi = pick(int'(t), i, 1'b0);
        ebq = pick(int'(t), q, 1'b0);
      end
    end
    check(tag, 32'({bus.valid_o, bus.first_o, bus.last_o, bus.ai_o, bus.aq_o, bus.bi_o, bus.bq_o}),
               32'({ev, ef, el, eai, eaq, ebi, ebq}));
  endtask

  function automatic logic [3:0] data_out();
    return {bus.ai_o, bus.aq_o, bus.bi_o, bus.bq_o};
  endfunction

  initial begin
    logic [11:0] ri, rq;
    logic [11:0] oh_a, oh_b;
    {ev, ef, el, eai, eaq, ebi, ebq} = 7'd0;

    for (int c = 0; c < 6; c++) begin
      step($sformatf("reset_hold%0d", c), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom), 12'($urandom), 12'($urandom));
    end
    step("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'hfff, 12'hfff);
    step("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'hfff, 12'hfff);

    // Table walk: I one-hot on the A antenna, Q one-hot on the B antenna, then swapped.
    for (int t = 0; t < 6; t++) begin
      oh_a = 12'd1 << walk_a[t];
      oh_b = 12'd1 << walk_b[t];
      step($sformatf("walk%0d", t), 1'b0, 1'b1, 1'b0, 1'b0, 3'(t), oh_a, oh_b);
      check($sformatf("walk%0d_hand", t), 32'(data_out()), 32'(4'b1001));
      step($sformatf("walk%0d_swap", t), 1'b0, 1'b1, 1'b0, 1'b0, 3'(t), oh_b, oh_a);
      check($sformatf("walk%0d_swap_hand", t), 32'(data_out()), 32'(4'b0110));
    end

    for (int k = 0; k < 90; k++) begin
      ri = 12'($urandom);
      rq = 12'($urandom);
      step($sformatf("frame%0d", k), 1'b0, 1'b1, 1'(k == 0), 1'(k == 89), 3'(k / 15), ri, rq);
    end

    // Gap: flags and data presented with valid_i low must be ignored.
    step("pre_gap", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 12'hfff, 12'hfff);
    for (int g = 0; g < 3; g++) begin
      step($sformatf("gap%0d", g), 1'b0, 1'b0, 1'b1, 1'b1, 3'(g), 12'h000, 12'h000);
      check($sformatf("gap%0d_hold", g), 32'(data_out()), 32'(4'b1111));
    end

    step("oor6", 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 12'hfff, 12'hfff);
    check("oor6_hand", 32'({bus.valid_o, data_out()}), 32'(5'b10000));
    step("inrange", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 12'hfff, 12'hfff);
    step("oor7", 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 12'hfff, 12'hfff);
    check("oor7_hand", 32'({bus.valid_o, data_out()}), 32'(5'b10000));

    for (int k = 0; k < 40; k++) begin
      step($sformatf("mid%0d", k), 1'b0, 1'b1, 1'(k == 0), 1'b0, 3'(k % 6), 12'($urandom), 12'($urandom));
    end
    step("mid_reset", 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 12'hfff, 12'hfff);
    check("mid_reset_hand", 32'({bus.valid_o, bus.first_o, bus.last_o, data_out()}), 32'(7'd0));
    step("post_reset_single", 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 12'h080, 12'h008);
    check("post_reset_hand", 32'({bus.valid_o, bus.first_o, bus.last_o, data_out()}), 32'(7'b1111001));
    step("post_reset_next", 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 12'($urandom), 12'($urandom));
    step("tail_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
